// File: rtl/nts_rx_dispatcher_pkg.sv
// Shared definitions for the NTS receive dispatcher.
//   MAC_MASK_FULL / MAC_MASK_IDLE : byte-valid mask values of the MAC RX word
//   NUM_BANKS                     : number of ping-pong packet buffers
//   wr_state_e                    : write-side frame capture states
package nts_rx_dispatcher_pkg;

  localparam logic [7:0]  MAC_MASK_FULL = 8'hff;
  localparam logic [7:0]  MAC_MASK_IDLE = 8'h00;
  localparam int unsigned NUM_BANKS     = 2;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/nts_rx_bank_mem.sv
// Two-bank packet buffer RAM, NUM_BANKS * 2**ADDR_WIDTH words of 64 bits.
// Address is {bank, word}. The read port is registered; the caller drives the
// address it wants to see on the *next* cycle (rd_addr_next), which gives the
// first-word-fall-through behaviour without an extra cycle of latency.
//   clk          in  clock
//   wr_en        in  write strobe
//   wr_addr      in  {bank, word} write address
//   wr_data      in  write data
//   rd_addr_next in  {bank, word} address to present on rd_data next cycle
//   rd_data      out registered read data
module nts_rx_bank_mem
  import nts_rx_dispatcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wr_addr,
  input  logic [63:0]           wr_data,
  input  logic [ADDR_WIDTH:0]   rd_addr_next,
  output logic [63:0]           rd_data
);

  localparam int unsigned DEPTH = NUM_BANKS << ADDR_WIDTH;

  logic [63:0] mem_q [0:DEPTH-1];
  logic [63:0] rd_data_d;
  logic [63:0] rd_data_q;

  // Write-first bypass: a one-word frame is written and committed in the same
  // cycle it becomes readable, so the fresh word must reach the read register.
  always_comb begin
    rd_data_d = mem_q[rd_addr_next];
    if (wr_en && (wr_addr == rd_addr_next)) begin
      rd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/nts_rx_dispatcher.sv
// Receive-side dispatcher in front of the NTS engine. Captures MAC RX frames
// into two ping-pong buffers and presents the oldest committed frame as an
// FWFT FIFO. Bad, overflowing or no-buffer frames are dropped and counted.
//   i_clk, i_areset_n                 clock, async active-low reset
//   i_rx_data_valid / i_rx_data       MAC byte mask and word (first byte [63:56])
//   i_rx_good_frame / i_rx_bad_frame  end-of-frame pulses
//   o_dispatch_packet_available       committed frame in read bank
//   i_dispatch_packet_read_discard    release read bank
//   o_dispatch_counter                word count of presented frame
//   o_dispatch_data_valid             byte mask of last word of presented frame
//   o_dispatch_fifo_empty / _rd_en / _rd_data   FWFT read interface
//   o_drop_count                      dropped frames, wraps
module nts_rx_dispatcher
  import nts_rx_dispatcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic [7:0]            i_rx_data_valid,
  input  logic [63:0]           i_rx_data,
  input  logic                  i_rx_good_frame,
  input  logic                  i_rx_bad_frame,
  output logic                  o_dispatch_packet_available,
  input  logic                  i_dispatch_packet_read_discard,
  output logic [ADDR_WIDTH-1:0] o_dispatch_counter,
  output logic [7:0]            o_dispatch_data_valid,
  output logic                  o_dispatch_fifo_empty,
  input  logic                  i_dispatch_fifo_rd_en,
  output logic [63:0]           o_dispatch_fifo_rd_data,
  output logic [31:0]           o_drop_count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  wr_state_e             state_q, state_d, word_state;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [NUM_BANKS-1:0]  full_q, full_d;
  logic [ADDR_WIDTH-1:0] len_q [NUM_BANKS];
  logic [ADDR_WIDTH-1:0] len_d [NUM_BANKS];
  logic [7:0]            last_mask_q [NUM_BANKS];
  logic [7:0]            last_mask_d [NUM_BANKS];
  logic [31:0]           drop_count_q, drop_count_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic                  word_in;
  logic                  commit;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH:0]   mem_wr_addr;
  logic [63:0]           mem_rd_data;
  logic                  rd_avail;
  logic                  rd_empty;

  // Write side. The incoming word is handled first (word_state), then any
  // end-of-frame pulse in the same cycle is evaluated against that state.
  always_comb begin
    state_d      = state_q;
    word_state   = state_q;
    wr_addr_d    = wr_addr_q;
    wr_bank_d    = wr_bank_q;
    len_d        = len_q;
    last_mask_d  = last_mask_q;
    drop_count_d = drop_count_q;
    mem_wr_en    = 1'b0;
    mem_wr_addr  = {wr_bank_q, wr_addr_q};
    commit       = 1'b0;
    word_in      = (i_rx_data_valid != MAC_MASK_IDLE);

    unique case (state_q)
      WR_IDLE: begin
        if (word_in) begin
          if (full_q[wr_bank_q]) begin
            word_state = WR_DROP;
          end else begin
            word_state             = WR_FILL;
            mem_wr_en              = 1'b1;
            mem_wr_addr            = {wr_bank_q, {ADDR_WIDTH{1'b0}}};
            wr_addr_d              = ADDR_WIDTH'(1);
            last_mask_d[wr_bank_q] = i_rx_data_valid;
          end
        end
      end
      WR_FILL: begin
        if (word_in) begin
          if (wr_addr_q == ADDR_MAX) begin
            word_state = WR_DROP;
          end else begin
            mem_wr_en              = 1'b1;
            wr_addr_d              = wr_addr_q + 1'b1;
            last_mask_d[wr_bank_q] = i_rx_data_valid;
          end
        end
      end
      WR_DROP: ;
      default: word_state = WR_IDLE;
    endcase

    state_d = word_state;
    if (i_rx_good_frame || i_rx_bad_frame) begin
      unique case (word_state)
        WR_FILL: begin
          if (i_rx_bad_frame) begin
            drop_count_d = drop_count_q + 1'b1;
          end else begin
            commit           = 1'b1;
            len_d[wr_bank_q] = wr_addr_d;
            wr_bank_d        = ~wr_bank_q;
          end
          state_d = WR_IDLE;
        end
        WR_DROP: begin
          drop_count_d = drop_count_q + 1'b1;
          state_d      = WR_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Read side. Discard outranks a pop in the same cycle.
  always_comb begin
    rd_avail  = full_q[rd_bank_q];
    rd_empty  = !rd_avail || (rd_addr_q == len_q[rd_bank_q]);
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    full_d    = full_q;
    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (i_dispatch_packet_read_discard && rd_avail) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      rd_addr_d         = '0;
    end else if (i_dispatch_fifo_rd_en && !rd_empty) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q      <= WR_IDLE;
      wr_addr_q    <= '0;
      wr_bank_q    <= 1'b0;
      full_q       <= '0;
      drop_count_q <= '0;
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        len_q[b]       <= '0;
        last_mask_q[b] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_bank_q    <= wr_bank_d;
      full_q       <= full_d;
      drop_count_q <= drop_count_d;
      rd_bank_q    <= rd_bank_d;
      rd_addr_q    <= rd_addr_d;
      len_q        <= len_d;
      last_mask_q  <= last_mask_d;
    end
  end

  nts_rx_bank_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk          (i_clk),
    .wr_en        (mem_wr_en),
    .wr_addr      (mem_wr_addr),
    .wr_data      (i_rx_data),
    .rd_addr_next ({rd_bank_d, rd_addr_d}),
    .rd_data      (mem_rd_data)
  );

  assign o_dispatch_packet_available = rd_avail;
  assign o_dispatch_counter          = rd_avail ? len_q[rd_bank_q] : '0;
  assign o_dispatch_data_valid       = rd_avail ? last_mask_q[rd_bank_q] : '0;
  assign o_dispatch_fifo_empty       = rd_empty;
  // Gated so the word is 0 at reset and never shows stale RAM content.
  assign o_dispatch_fifo_rd_data     = rd_empty ? '0 : mem_rd_data;
  assign o_drop_count                = drop_count_q;

endmodule

// File: tb/tb_nts_rx_dispatcher.sv
module tb_nts_rx_dispatcher;

  localparam int AW   = 8;
  localparam int MAXW = (1 << AW) - 1;
  localparam int VW   = AW + 106;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_valid = '0;
  logic [63:0]   rx_data = '0;
  logic          rx_good = 1'b0;
  logic          rx_bad = 1'b0;
  logic          avail;
  logic          discard = 1'b0;
  logic [AW-1:0] counter;
  logic [7:0]    dvalid;
  logic          empty;
  logic          rd_en = 1'b0;
  logic [63:0]   rd_data;
  logic [31:0]   drops;

  nts_rx_dispatcher #(.ADDR_WIDTH(AW)) dut (
    .i_clk                          (clk),
    .i_areset_n                     (rst_n),
    .i_rx_data_valid                (rx_valid),
    .i_rx_data                      (rx_data),
    .i_rx_good_frame                (rx_good),
    .i_rx_bad_frame                 (rx_bad),
    .o_dispatch_packet_available    (avail),
    .i_dispatch_packet_read_discard (discard),
    .o_dispatch_counter             (counter),
    .o_dispatch_data_valid          (dvalid),
    .o_dispatch_fifo_empty          (empty),
    .i_dispatch_fifo_rd_en          (rd_en),
    .o_dispatch_fifo_rd_data        (rd_data),
    .o_drop_count                   (drops)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad_cnt = 0;

  // Reference model: committed frames form a FIFO of at most two entries,
  // stored as one concatenated word queue plus per-frame length and mask.
  logic [63:0] m_words[$];
  int          m_len[$];
  logic [7:0]  m_mask[$];
  int          m_rd_ptr;
  logic [63:0] m_cur[$];
  logic [7:0]  m_cur_mask;
  bit          m_in_frame;
  bit          m_dropping;
  logic [31:0] m_drops;

  function automatic void model_reset();
    m_words.delete(); m_len.delete(); m_mask.delete(); m_cur.delete();
    m_rd_ptr = 0; m_cur_mask = '0; m_in_frame = 0; m_dropping = 0; m_drops = '0;
  endfunction

  function automatic void model_step(logic [7:0] v, logic [63:0] d, bit g, bit b, bit disc, bit rd);
    int occ;
    occ = m_len.size();
    if (disc && occ > 0) begin
      for (int i = 0; i < m_len[0]; i++) void'(m_words.pop_front());
      void'(m_len.pop_front());
      void'(m_mask.pop_front());
      m_rd_ptr = 0;
    end else if (rd && occ > 0 && m_rd_ptr < m_len[0]) begin
      m_rd_ptr++;
    end
    if (v != 8'h00) begin
      if (!m_in_frame) begin
        m_in_frame = 1;
        m_dropping = (occ == 2);
        m_cur.delete();
        if (!m_dropping) begin m_cur.push_back(d); m_cur_mask = v; end
      end else if (!m_dropping) begin
        if (m_cur.size() == MAXW) m_dropping = 1;
        else begin m_cur.push_back(d); m_cur_mask = v; end
      end
    end
    if ((g || b) && m_in_frame) begin
      if (m_dropping || b) m_drops++;
      else begin
        foreach (m_cur[i]) m_words.push_back(m_cur[i]);
        m_len.push_back(m_cur.size());
        m_mask.push_back(m_cur_mask);
      end
      m_in_frame = 0;
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic          e_av, e_empty;
    logic [AW-1:0] e_cnt;
    logic [7:0]    e_dv;
    logic [63:0]   e_data;
    e_av = (m_len.size() > 0);
    e_cnt = '0; e_dv = '0; e_data = '0; e_empty = 1'b1;
    if (e_av) begin
      e_cnt   = AW'(m_len[0]);
      e_dv    = m_mask[0];
      e_empty = (m_rd_ptr == m_len[0]);
      if (!e_empty) e_data = m_words[m_rd_ptr];
    end
    return {e_av, e_cnt, e_dv, e_empty, e_data, m_drops};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {avail, counter, dvalid, empty, rd_data, drops};
  endfunction

  task automatic cycle(input logic [7:0] v, input logic [63:0] d, input bit g, input bit b,
                       input bit disc, input bit rd);
    rx_valid = v; rx_data = d; rx_good = g; rx_bad = b; discard = disc; rd_en = rd;
    @(posedge clk);
    model_step(v, d, g, b, disc, rd);
    #1;
    rx_valid = '0; rx_data = '0; rx_good = 0; rx_bad = 0; discard = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(8'h00, '0, 0, 0, 0, 0);
  endtask

  // Sends n words (last one with last_mask), returns them, then one end pulse.
  task automatic send_frame(input int n, input logic [7:0] last_mask, input bit good,
                            output logic [63:0] w[$]);
    logic [63:0] d;
    w.delete();
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      w.push_back(d);
      cycle((i == n - 1) ? last_mask : 8'hff, d, 0, 0, 0, 0);
    end
    cycle(8'h00, '0, good, !good, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs() !== exp_vec()) begin
      bad_cnt++; $display("FAIL reset_vec: got %h want %h", obs(), exp_vec());
    end
    total++;
    if ({avail, counter, dvalid, empty, rd_data, drops} !== {1'b0, {AW{1'b0}}, 8'h00, 1'b1, 64'h0, 32'h0}) begin
      bad_cnt++; $display("FAIL reset_const: avail=%0b cnt=%0d dv=%h empty=%0b drops=%0d want 0/0/00/1/0",
                          avail, counter, dvalid, empty, drops);
    end
  endtask

  task automatic test_basic();
    logic [63:0] w[$];
    do_reset();
    send_frame(4, 8'h0f, 1, w);
    total++;
    if (avail !== 1'b1 || counter !== AW'(4) || dvalid !== 8'h0f || empty !== 1'b0) begin
      bad_cnt++; $display("FAIL basic_commit: avail=%0b cnt=%0d dv=%h empty=%0b want 1/4/0f/0",
                          avail, counter, dvalid, empty);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rd_data !== w[i] || empty !== 1'b0) begin
        bad_cnt++; $display("FAIL basic_pop%0d: data=%h empty=%0b want %h/0", i, rd_data, empty, w[i]);
      end
      cycle(8'h00, '0, 0, 0, 0, 1);
    end
    total++;
    if (empty !== 1'b1 || avail !== 1'b1) begin
      bad_cnt++; $display("FAIL basic_drained: empty=%0b avail=%0b want 1/1", empty, avail);
    end
    cycle(8'h00, '0, 0, 0, 0, 1);   // pop while empty is ignored
    cycle(8'h00, '0, 0, 0, 1, 0);
    total++;
    if (obs() !== exp_vec() || avail !== 1'b0) begin
      bad_cnt++; $display("FAIL basic_discard: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_bad_frame();
    logic [63:0] w[$];
    do_reset();
    send_frame(3, 8'hff, 0, w);
    total++;
    if (avail !== 1'b0 || drops !== 32'd1) begin
      bad_cnt++; $display("FAIL bad_frame: avail=%0b drops=%0d want 0/1", avail, drops);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] w[$];
    do_reset();
    send_frame(MAXW + 1, 8'hff, 1, w);
    total++;
    if (avail !== 1'b0 || drops !== 32'd1) begin
      bad_cnt++; $display("FAIL overflow_drop: avail=%0b drops=%0d want 0/1", avail, drops);
    end
    send_frame(2, 8'h03, 1, w);
    total++;
    if (avail !== 1'b1 || counter !== AW'(2) || dvalid !== 8'h03 || rd_data !== w[0]) begin
      bad_cnt++; $display("FAIL overflow_next: avail=%0b cnt=%0d dv=%h data=%h want 1/2/03/%h",
                          avail, counter, dvalid, rd_data, w[0]);
    end
    total++;
    if (obs() !== exp_vec()) begin
      bad_cnt++; $display("FAIL overflow_vec: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] wa[$], wb[$], wc[$];
    do_reset();
    send_frame(3, 8'hff, 1, wa);
    send_frame(2, 8'h7f, 1, wb);
    send_frame(2, 8'hff, 1, wc);
    total++;
    if (avail !== 1'b1 || counter !== AW'(3) || rd_data !== wa[0] || drops !== 32'd1) begin
      bad_cnt++; $display("FAIL b2b_full: avail=%0b cnt=%0d data=%h drops=%0d want 1/3/%h/1",
                          avail, counter, rd_data, drops, wa[0]);
    end
    cycle(8'h00, '0, 0, 0, 1, 0);
    total++;
    if (avail !== 1'b1 || counter !== AW'(2) || dvalid !== 8'h7f || rd_data !== wb[0]) begin
      bad_cnt++; $display("FAIL b2b_second: avail=%0b cnt=%0d dv=%h data=%h want 1/2/7f/%h",
                          avail, counter, dvalid, rd_data, wb[0]);
    end
    total++;
    if (obs() !== exp_vec()) begin
      bad_cnt++; $display("FAIL b2b_vec: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_discard_commit();
    logic [63:0] wa[$], wb[$];
    do_reset();
    send_frame(2, 8'hff, 1, wa);
    wb.delete();
    for (int i = 0; i < 3; i++) wb.push_back({$urandom, $urandom});
    cycle(8'hff, wb[0], 0, 0, 0, 0);
    cycle(8'hff, wb[1], 0, 0, 0, 0);
    cycle(8'h0f, wb[2], 1, 0, 1, 0);   // last word + good + discard together
    total++;
    if (avail !== 1'b1 || counter !== AW'(3) || dvalid !== 8'h0f || rd_data !== wb[0]) begin
      bad_cnt++; $display("FAIL disc_commit: avail=%0b cnt=%0d dv=%h data=%h want 1/3/0f/%h",
                          avail, counter, dvalid, rd_data, wb[0]);
    end
    total++;
    if (obs() !== exp_vec()) begin
      bad_cnt++; $display("FAIL disc_commit_vec: got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0]  v;
    logic [63:0] d;
    bit          g, b;
    int          r;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 9) < 6) ? (8'hff >> $urandom_range(0, 7)) : 8'h00;
      d = {$urandom, $urandom};
      r = $urandom_range(0, 19);
      g = (r < 2);
      b = (r == 2);
      cycle(v, d, g, b, ($urandom_range(0, 11) == 0), $urandom_range(0, 1) == 1);
      total++;
      if (obs() !== exp_vec()) begin
        bad_cnt++; $display("FAIL random_c%0d: got %h want %h", n, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] w[$];
    do_reset();
    send_frame(2, 8'hff, 0, w);      // drop_count becomes nonzero
    send_frame(4, 8'hff, 1, w);
    cycle(8'h00, '0, 0, 0, 0, 1);    // mid-read
    cycle(8'hff, 64'h1111, 0, 0, 0, 0);
    cycle(8'hff, 64'h2222, 0, 0, 0, 0);  // mid-fill
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({avail, counter, dvalid, empty, rd_data, drops} !== {1'b0, {AW{1'b0}}, 8'h00, 1'b1, 64'h0, 32'h0}) begin
      bad_cnt++; $display("FAIL async_reset: avail=%0b cnt=%0d dv=%h empty=%0b data=%h drops=%0d want 0/0/00/1/0/0",
                          avail, counter, dvalid, empty, rd_data, drops);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(8'h00, '0, 0, 0, 0, 0);
    send_frame(1, 8'h01, 1, w);
    total++;
    if (obs() !== exp_vec() || counter !== AW'(1) || rd_data !== w[0]) begin
      bad_cnt++; $display("FAIL async_after: got %h want %h", obs(), exp_vec());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_bad_frame();
    test_overflow();
    test_back_to_back();
    test_discard_commit();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
